// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies,
// FSM state type and the MD-class decode reused by the hazard unit.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // True for the multi-cycle ops (mult/multu/div/divu) that must stall dependents.
  function automatic logic is_md(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/status bundle between the Execute stage and the multiply/divide unit.
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  // start qualifies md_op/A/B for one cycle; an MD op is accepted only when busy=0,
  // and anything presented while busy=1 is dropped (no backpressure, no queueing).
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        md_active;
  logic [31:0] HI;
  logic [31:0] LO;
  md_state_e   dbg_state;

  modport master (
    output start, md_op, A, B,
    input  busy, md_active, HI, LO, dbg_state
  );

  modport slave (
    input  start, md_op, A, B,
    output busy, md_active, HI, LO, dbg_state
  );

endinterface

// File: rtl/mult_div_unit_md_arith.sv
// Combinational multiply/divide datapath producing the {hi,lo} result for one op.
module md_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_result
);

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic signed [31:0] w_quot_s;
  logic signed [31:0] w_rem_s;
  logic        [31:0] w_quot_u;
  logic        [31:0] w_rem_u;
  logic               w_div_zero;
  logic               w_div_ovf;

  assign w_prod_s   = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u   = {32'd0, i_a} * {32'd0, i_b};
  assign w_quot_s   = $signed(i_a) / $signed(i_b);
  assign w_rem_s    = $signed(i_a) % $signed(i_b);
  assign w_quot_u   = i_a / i_b;
  assign w_rem_u    = i_a % i_b;
  assign w_div_zero = (i_b == 32'd0);
  // -2^31 / -1 overflows the quotient; pin it to the wrapped value with zero remainder.
  assign w_div_ovf  = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  always_comb begin
    o_result = {i_hi, i_lo};
    case (i_op)
      MD_MULT:  o_result = w_prod_s;
      MD_MULTU: o_result = w_prod_u;
      MD_DIV: begin
        if (w_div_zero)     o_result = {i_hi, i_lo};
        else if (w_div_ovf) o_result = {32'd0, 32'h8000_0000};
        else                o_result = {w_rem_s, w_quot_s};
      end
      MD_DIVU: begin
        if (w_div_zero) o_result = {i_hi, i_lo};
        else            o_result = {w_rem_u, w_quot_u};
      end
      default: o_result = {i_hi, i_lo};
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO: result is computed at issue, parked in a
// pending register, and committed to HI/LO when the latency counter expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave md
);

  if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
    $error("MULT_CYCLES must be in 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
    $error("DIV_CYCLES must be in 1..15");
  end

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_pend;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  md_state_e   w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [63:0] w_pend_nxt;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic [63:0] w_result;
  logic        w_issue;

  md_arith u_md_arith (
    .i_op     (md.md_op),
    .i_a      (md.A),
    .i_b      (md.B),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_result (w_result)
  );

  assign w_issue = md.start && (r_state == ST_IDLE) && is_md(md.md_op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_pend  <= 64'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = is_mult(md.md_op) ? MULT_CNT : DIV_CNT;
          w_pend_nxt  = w_result;
        end else if (md.start && (md.md_op == MD_MTHI)) begin
          w_hi_nxt = md.A;
        end else if (md.start && (md.md_op == MD_MTLO)) begin
          w_lo_nxt = md.A;
        end
      end
      ST_BUSY: begin
        // Inputs are ignored here: whatever arrives while busy is dropped.
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
          w_hi_nxt    = r_pend[63:32];
          w_lo_nxt    = r_pend[31:0];
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    md.busy      = (r_state == ST_BUSY);
    md.md_active = (md.start && is_md(md.md_op)) || (r_state == ST_BUSY);
    md.HI        = r_hi;
    md.LO        = r_lo;
    md.dbg_state = r_state;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table for the arithmetic, hand sequences for
// MTHI/MTLO, divide-by-zero, ops while busy and asynchronous reset mid-operation.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if u_if ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (u_if)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t        vecs[9];
  logic [63:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    u_if.start = 1'b0;
    u_if.md_op = MD_NONE;
    u_if.A     = 32'd0;
    u_if.B     = 32'd0;
  endtask

  // Issue an MD op from idle and count the cycles busy stays high afterwards.
  task automatic issue_wait(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, output int cycles);
    u_if.start = 1'b1;
    u_if.md_op = op;
    u_if.A     = a;
    u_if.B     = b;
    #1;
    check({name, " md_active at issue"}, 64'(u_if.md_active), 64'd1);
    check({name, " busy at issue"}, 64'(u_if.busy), 64'd0);
    tick();
    drive_idle();
    cycles = 0;
    while (u_if.busy && cycles < 40) begin
      cycles++;
      tick();
    end
  endtask

  task automatic move_to(input string name, input logic [2:0] op, input logic [31:0] a);
    u_if.start = 1'b1;
    u_if.md_op = op;
    u_if.A     = a;
    #1;
    check({name, " md_active"}, 64'(u_if.md_active), 64'd0);
    tick();
    drive_idle();
    check({name, " busy"}, 64'(u_if.busy), 64'd0);
  endtask

  initial begin
    int          cycles;
    logic [63:0] exp;

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 5};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{MD_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         10};
    vecs[4] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[5] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[6] = '{MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         10};
    vecs[7] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h10,       32'hF,         32'h0FFF_FFFF, 10};
    vecs[8] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        5};

    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(u_if.busy), 64'd0);
    check("reset HI", 64'(u_if.HI), 64'd0);
    check("reset LO", 64'(u_if.LO), 64'd0);
    check("reset state", 64'(u_if.dbg_state), 64'(ST_IDLE));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({vecs[i].hi, vecs[i].lo});
      issue_wait($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, cycles);
      exp = exp_q.pop_front();
      check($sformatf("vec%0d busy cycles", i), 64'(cycles), 64'(vecs[i].cyc));
      check($sformatf("vec%0d HI", i), 64'(u_if.HI), 64'(exp[63:32]));
      check($sformatf("vec%0d LO", i), 64'(u_if.LO), 64'(exp[31:0]));
    end

    // Back-to-back MTHI then MTLO, single cycle each, never busy.
    move_to("mthi", MD_MTHI, 32'h1234);
    check("mthi HI", 64'(u_if.HI), 64'h1234);
    move_to("mtlo", MD_MTLO, 32'h5678);
    check("mtlo HI", 64'(u_if.HI), 64'h1234);
    check("mtlo LO", 64'(u_if.LO), 64'h5678);

    // NONE and reserved encodings have no effect.
    u_if.start = 1'b1; u_if.md_op = MD_NONE; u_if.A = 32'hDEAD_BEEF; u_if.B = 32'd9;
    tick();
    u_if.md_op = MD_RSVD;
    #1;
    check("rsvd md_active", 64'(u_if.md_active), 64'd0);
    tick();
    drive_idle();
    check("none/rsvd busy", 64'(u_if.busy), 64'd0);
    check("none/rsvd HI", 64'(u_if.HI), 64'h1234);
    check("none/rsvd LO", 64'(u_if.LO), 64'h5678);

    // Divide by zero: full latency, HI/LO preserved.
    issue_wait("div0", MD_DIV, 32'd5, 32'd0, cycles);
    check("div0 busy cycles", 64'(cycles), 64'd10);
    check("div0 HI", 64'(u_if.HI), 64'h1234);
    check("div0 LO", 64'(u_if.LO), 64'h5678);
    issue_wait("divu0", MD_DIVU, 32'd5, 32'd0, cycles);
    check("divu0 busy cycles", 64'(cycles), 64'd10);
    check("divu0 HI", 64'(u_if.HI), 64'h1234);
    check("divu0 LO", 64'(u_if.LO), 64'h5678);

    // Overflow divide, with a MULT and an MTHI thrown at it mid-flight.
    u_if.start = 1'b1; u_if.md_op = MD_DIV; u_if.A = 32'h8000_0000; u_if.B = 32'hFFFF_FFFF;
    tick();
    drive_idle();
    cycles = 0;
    while (u_if.busy && cycles < 40) begin
      cycles++;
      if (cycles == 3) begin
        u_if.start = 1'b1; u_if.md_op = MD_MULT; u_if.A = 32'd2; u_if.B = 32'd3;
      end else if (cycles == 5) begin
        u_if.start = 1'b1; u_if.md_op = MD_MTHI; u_if.A = 32'hAAAA;
      end else begin
        drive_idle();
      end
      tick();
    end
    drive_idle();
    check("ovf busy cycles", 64'(cycles), 64'd10);
    check("ovf HI", 64'(u_if.HI), 64'd0);
    check("ovf LO", 64'(u_if.LO), 64'h8000_0000);
    tick();
    check("ovf no late issue", 64'(u_if.busy), 64'd0);

    // Reset during busy cycle 2 clears everything before the next edge.
    move_to("mthi pre-reset", MD_MTHI, 32'hCAFE);
    u_if.start = 1'b1; u_if.md_op = MD_MULT; u_if.A = 32'd100; u_if.B = 32'd100;
    tick();
    drive_idle();
    tick();
    check("pre-reset busy", 64'(u_if.busy), 64'd1);
    check("pre-reset state", 64'(u_if.dbg_state), 64'(ST_BUSY));
    #2 reset = 1'b1;
    #1;
    check("async reset busy", 64'(u_if.busy), 64'd0);
    check("async reset HI", 64'(u_if.HI), 64'd0);
    check("async reset LO", 64'(u_if.LO), 64'd0);
    #2 reset = 1'b0;
    repeat (8) tick();
    check("post-reset busy", 64'(u_if.busy), 64'd0);
    check("post-reset HI", 64'(u_if.HI), 64'd0);
    check("post-reset LO", 64'(u_if.LO), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, instantiated in the Execute stage.
- Its results are read by MFHI/MFLO and carried in the pipeline info bundle into the Memory stage.
- Exposes busy/active status so the hazard unit can stall MD-class instructions in Decode until HI/LO are final.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle qualifier: the op on md_op is issued this cycle
- md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- A  input  32  rs operand (forwarded value)
- B  input  32  rt operand (forwarded value)
- busy  output  1  computation in progress
- md_active  output  1  combinational start&(md_op in 1..4) | busy, consumed by the hazard unit
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - HI=0, LO=0, busy=0, cycle counter=0.
  - The pending result is discarded.
- Issue condition: start=1, busy=0, md_op in 1..4, sampled at clock edge t.
  - The result is computed from A/B as sampled at edge t and held in a pending {hi,lo} register.
  - counter loads MULT_CYCLES or DIV_CYCLES; busy=1 from edge t.
- While busy:
  - counter decrements each edge.
  - At the edge where counter goes 1→0: HI/LO take the pending result and busy drops.
  - busy is therefore high for exactly N cycles; the new HI/LO are visible the cycle busy is first 0.
- Arithmetic:
  - MULT: signed 32x32→64; HI=prod[63:32], LO=prod[31:0].
  - MULTU: same, unsigned.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - DIVU: unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0): the unit still goes busy for DIV_CYCLES, but HI/LO retain their prior values at completion.
- MTHI/MTLO with start=1, busy=0: HI (or LO) = A at the next edge; single-cycle; busy stays 0; md_active not asserted.
- Ops issued while busy=1 (any md_op, including MTHI/MTLO): ignored. HI/LO and counter are unaffected. The hazard unit guarantees this never happens; the bench asserts it.
- start=1 with md_op NONE/7: no effect.
- HI/LO are never written combinationally. Reads during busy return the old values; the hazard unit must stall MFHI/MFLO while md_active=1.
- The counter is 4 bits wide; parameters outside 1..15 are illegal (elaboration check).

Decomposition:
- Add to the shared macros file:
  - the md_op encodings (MD_NONE..MD_MTLO);
  - the default cycle constants;
  - an isMD decode macro (mult/multu/div/divu) for hazard-unit reuse.
- Sub-module md_arith: purely combinational, inputs (op, A, B, old HI, old LO) → 64-bit {hi,lo} result.
  - Contains the signed/unsigned multiply and divide.
  - Contains the divide-by-zero hold and the overflow rule.
- mult_div_unit holds the counter, pending register, HI/LO and busy logic.

Test Plan:
- Reset then MULT A=0xFFFFFFFE (-2), B=3 → busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands → HI=0x2, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 → LO=3, HI=1.
- MTHI A=0x1234 then MTLO A=0x5678 back-to-back → HI=0x1234, LO=0x5678, busy never asserts; then DIV by B=0 → busy 10 cycles, HI/LO unchanged.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0; issue MULT during cycle 3 of busy → ignored, HI/LO unchanged after completion.
- MULT 100*100 started, assert reset at busy cycle 2 → busy=0, HI=LO=0 immediately (asynchronously, before the next edge), no later write of 10000.
- md_active: start=1 with MULT while idle → md_active=1 the same cycle with busy=0; MTLO → md_active=0.
